aes_bus_ctrl: RTL and testbench
===============================

Name: aes_bus_ctrl

Overview:
- Sits between the byte-wide host bus (valid/wen/addr/wdata/rdata, as delivered by the pad ring) and the 128-bit AES core.
- Assembles the 128-bit key and plaintext from byte writes and sequences the core through start/busy/done.
- Captures the 128-bit result and exposes it, with status and error flags, through byte-wide reads.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles from core_start to core_done before an error is declared; must be ≥2.
- CHIP_ID, 8'hA5: constant returned when reading address 0x3F.

Ports:
- clk  in  1  system clock; every register is clocked on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid  in  1  bus transaction strobe, one cycle per transaction.
- wen  in  1  1 = write, 0 = read; sampled only when valid=1.
- addr  in  8  byte address.
- wdata  in  8  write data.
- rdata  out  8  read data, registered.
- core_key  out  128  key to the core; byte at addr 0x00 drives [127:120].
- core_din  out  128  plaintext to the core; byte at addr 0x10 drives [127:120].
- core_start  out  1  single-cycle start pulse.
- core_done  in  1  single-cycle pulse from the core; core_dout is valid in that cycle.
- core_dout  in  128  result; byte at addr 0x20 reads [127:120].
- irq  out  1  level output, equal to done_flag & irq_en.

Behaviour:
- Reset values: rdata=0, core_key=0, core_din=0, core_start=0, irq=0, result=0, all flags=0, irq_en=0, FSM in IDLE.
- Address map:
  - 0x00-0x0F: key bytes, read/write.
  - 0x10-0x1F: plaintext bytes, read/write.
  - 0x20-0x2F: result bytes, read-only.
  - 0x30: CTRL, write. bit0 = start (self-clearing), bit1 = clear done and error, bit2 = irq_en (stored). A read returns {5'b0, irq_en, 2'b0}.
  - 0x31: STATUS, read-only. {5'b0, error, done, busy}.
  - 0x3F: CHIP_ID.
  - Any other address reads 0x00. Writes to read-only or unmapped addresses are ignored.
- Read: when valid=1 and wen=0 in cycle N, rdata shows the addressed byte in cycle N+1. rdata holds its value between reads.
- Write: when valid=1 and wen=1, the write takes effect at the next clock edge.
- FSM states:
  - IDLE: a CTRL write with bit0=1 moves to START.
  - START: core_start=1 for exactly one cycle, timeout counter cleared; next state BUSY.
  - BUSY: busy=1. On core_done, latch core_dout into result, set done, go to IDLE. If the counter reaches TIMEOUT_CYCLES without core_done, set error and go to IDLE; the result register keeps its old value.
- Writes to 0x00-0x1F while in START or BUSY are dropped and set error. The key and plaintext presented to the core therefore stay stable for the whole operation.
- A start request while in START or BUSY is ignored and sets error.
- A CTRL write with bit1=1 and bit0=1 together: clear is applied first, then start. An error raised by the start attempt in that same write survives the clear.
- A core_done outside BUSY is ignored.
- done and error are sticky. They clear only on a CTRL bit1 write or on reset.
- A new start does not clear done. Software clears it.
- Reset during BUSY: return to IDLE with all reset values. A core_done arriving later is ignored.
- The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.

Decomposition:
- Package aes_bus_pkg holds:
  - address constants: KEY_BASE=0x00, PT_BASE=0x10, RES_BASE=0x20, CTRL=0x30, STATUS=0x31, ID=0x3F;
  - CTRL and STATUS bit indices;
  - FSM state enum {IDLE, START, BUSY}.
- One natural sub-module: aes_byte_regfile, a 16x8 write-port register bank with a flattened 128-bit output, instantiated twice (key and plaintext).
- Result capture, FSM and read mux stay in the top module.

Test Plan:
- Reset check: assert reset for 2 cycles, then read 0x31, 0x3F and 0x05. Required: rdata = 0x00, 0xA5 and 0x00 respectively, core_start=0, irq=0.
- FIPS-197 vector: write key 00 01 .. 0f to 0x00-0x0F and plaintext 00 11 22 .. ff to 0x10-0x1F, then write 0x30=0x05. Required:
  - core_start high for exactly one cycle, STATUS=0x01 while waiting;
  - after core_done, STATUS=0x02 and irq=1;
  - reads of 0x20-0x2F return 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
- Busy protection: while BUSY, write 0x00=0xFF and write 0x30=0x01. Required: core_key[127:120] unchanged, no second core_start, STATUS bit2=1 after completion.
- Timeout: core stub never pulses core_done. Required: BUSY for exactly 64 cycles after START, then STATUS=0x04, result bytes unchanged, a new start is accepted.
- Clear and restart: write 0x30=0x02. Required: STATUS=0x00 and irq=0. Then write 0x30=0x03: start proceeds with error=0.
- Reset mid-operation: assert reset during BUSY, then pulse core_done 3 cycles later. Required: STATUS=0x00, result reads 0x00, done stays 0.

Source files
------------

// File: rtl/aes_bus_pkg.sv
// Shared address map, register bit positions and FSM encoding for the AES bus controller.
package aes_bus_pkg;

   localparam logic [7:0] KEY_BASE = 8'h00;
   localparam logic [7:0] PT_BASE  = 8'h10;
   localparam logic [7:0] RES_BASE = 8'h20;
   localparam logic [7:0] CTRL     = 8'h30;
   localparam logic [7:0] STATUS   = 8'h31;
   localparam logic [7:0] ID       = 8'h3F;

   localparam int CTRL_START  = 0;
   localparam int CTRL_CLEAR  = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_DONE  = 1;
   localparam int STAT_ERROR = 2;

   typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

   // Byte 0 sits in the most significant lane, so lane offset is 8*(15-idx).
   function automatic logic [7:0] byte_of(input logic [127:0] v, input logic [3:0] idx);
      return v[{~idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/aes_byte_regfile.sv
// 16-entry byte register bank, written one byte at a time and exposed as one 128-bit word.
module aes_byte_regfile (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [3:0]   waddr,
   input  logic [7:0]   wdata,
   output logic [127:0] q
);

   // NOTE: this bank is reset, unlike a plain RAM, because the core must see an all-zero key/plaintext after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (we) begin
         q[{~waddr, 3'b000} +: 8] <= wdata;
      end
   end

endmodule

// File: rtl/aes_bus_ctrl.sv
// Byte-wide host bus front end for a 128-bit AES core: operand assembly, start/done sequencing,
// result capture and status reporting.
module aes_bus_ctrl
   import aes_bus_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 64,
   parameter logic [7:0] CHIP_ID        = 8'hA5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid,
   input  logic         wen,
   input  logic [7:0]   addr,
   input  logic [7:0]   wdata,
   output logic [7:0]   rdata,
   output logic [127:0] core_key,
   output logic [127:0] core_din,
   output logic         core_start,
   input  logic         core_done,
   input  logic [127:0] core_dout,
   output logic         irq
);

   localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_inc;
   logic [127:0]       result;
   logic               done;
   logic               error;
   logic               irq_en;
   logic [7:0]         rd_byte;

   logic wr, rd, wr_key, wr_pt, wr_ctrl, op_active, start_req;

   assign wr        = valid & wen;
   assign rd        = valid & ~wen;
   assign wr_key    = wr && (addr[7:4] == KEY_BASE[7:4]);
   assign wr_pt     = wr && (addr[7:4] == PT_BASE[7:4]);
   assign wr_ctrl   = wr && (addr == CTRL);
   assign start_req = wr_ctrl & wdata[CTRL_START];
   assign op_active = (state != IDLE);
   assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
   assign irq       = done & irq_en;

   // Operand writes are gated off while an operation runs so the core sees stable inputs.
   aes_byte_regfile u_key (
      .clk   (clk),
      .reset (reset),
      .we    (wr_key & ~op_active),
      .waddr (addr[3:0]),
      .wdata (wdata),
      .q     (core_key)
   );

   aes_byte_regfile u_pt (
      .clk   (clk),
      .reset (reset),
      .we    (wr_pt & ~op_active),
      .waddr (addr[3:0]),
      .wdata (wdata),
      .q     (core_din)
   );

   // NOTE: rd_byte gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      rd_byte = 8'h00;
      if (addr[7:4] == KEY_BASE[7:4]) begin
         rd_byte = byte_of(core_key, addr[3:0]);
      end else if (addr[7:4] == PT_BASE[7:4]) begin
         rd_byte = byte_of(core_din, addr[3:0]);
      end else if (addr[7:4] == RES_BASE[7:4]) begin
         rd_byte = byte_of(result, addr[3:0]);
      end else if (addr == CTRL) begin
         rd_byte[CTRL_IRQ_EN] = irq_en;
      end else if (addr == STATUS) begin
         rd_byte[STAT_BUSY]  = (state == BUSY);
         rd_byte[STAT_DONE]  = done;
         rd_byte[STAT_ERROR] = error;
      end else if (addr == ID) begin
         rd_byte = CHIP_ID;
      end
   end

   // NOTE: non-blocking assignments let later statements override earlier ones within an edge;
   // the flag clear is written first so any error raised in the same cycle survives it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         result     <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
         irq_en     <= 1'b0;
         core_start <= 1'b0;
         rdata      <= 8'h00;
      end else begin
         core_start <= 1'b0;

         if (rd) begin
            rdata <= rd_byte;
         end

         if (wr_ctrl) begin
            irq_en <= wdata[CTRL_IRQ_EN];
            if (wdata[CTRL_CLEAR]) begin
               done  <= 1'b0;
               error <= 1'b0;
            end
         end

         case (state)
            IDLE: begin
               if (start_req) begin
                  state      <= START;
                  core_start <= 1'b1;
               end
            end
            START: begin
               cnt   <= '0;
               state <= BUSY;
            end
            BUSY: begin
               cnt <= cnt_inc;
               if (core_done) begin
                  result <= core_dout;
                  done   <= 1'b1;
                  state  <= IDLE;
               end else if (cnt_inc == CNT_MAX) begin
                  error <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (op_active && (wr_key || wr_pt || start_req)) begin
            error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_aes_bus_ctrl.sv
// Self-checking bench for aes_bus_ctrl: register-map table, FSM corner sequences and a
// randomized phase checked against an array-based model of the register map.
module tb_aes_bus_ctrl;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         valid = 1'b0;
   logic         wen = 1'b0;
   logic [7:0]   addr = 8'h00;
   logic [7:0]   wdata = 8'h00;
   logic [7:0]   rdata;
   logic [127:0] core_key;
   logic [127:0] core_din;
   logic         core_start;
   logic         core_done = 1'b0;
   logic [127:0] core_dout = '0;
   logic         irq;

   int n_checks = 0;
   int n_pass = 0;
   int start_count = 0;

   aes_bus_ctrl #(.TIMEOUT_CYCLES(64), .CHIP_ID(8'hA5)) dut (
      .clk        (clk),
      .reset      (reset),
      .valid      (valid),
      .wen        (wen),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .core_key   (core_key),
      .core_din   (core_din),
      .core_start (core_start),
      .core_done  (core_done),
      .core_dout  (core_dout),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (core_start === 1'b1) start_count <= start_count + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   typedef struct {
      logic       wen;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[20];

   // Register-map model used by the randomized phase.
   logic [7:0] key_m[16];
   logic [7:0] pt_m[16];
   logic [7:0] res_m[16];
   logic       done_m, err_m, irq_en_m;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      check(name, {120'b0, act}, {120'b0, exp});
   endtask

   // Bus tasks are entered at a falling edge and return at the next falling edge.
   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      valid = 1'b1; wen = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      valid = 1'b0; wen = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
      valid = 1'b1; wen = 1'b0; addr = a;
      @(negedge clk);
      valid = 1'b0;
      d = rdata;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
   endtask

   task automatic pulse_done(input logic [127:0] v);
      core_done = 1'b1; core_dout = v;
      @(negedge clk);
      core_done = 1'b0;
   endtask

   function automatic logic [127:0] pack(input logic [7:0] b[16]);
      logic [127:0] v = '0;
      for (int i = 0; i < 16; i++) v = (v << 8) | {120'b0, b[i]};
      return v;
   endfunction

   function automatic logic [7:0] model_read(input logic [7:0] a);
      if (a < 8'h10)       return key_m[a[3:0]];
      else if (a < 8'h20)  return pt_m[a[3:0]];
      else if (a < 8'h30)  return res_m[a[3:0]];
      else if (a == 8'h30) return {5'b0, irq_en_m, 2'b0};
      else if (a == 8'h31) return {5'b0, err_m, done_m, 1'b0};
      else if (a == 8'h3F) return 8'hA5;
      return 8'h00;
   endfunction

   initial begin
      logic [7:0]   s;
      logic [127:0] fips_res;
      logic [127:0] res_b;
      logic [127:0] res_c;
      logic [127:0] tmp;
      int           sc0;
      int           busy_cnt;
      logic [7:0]   last;

      fips_res = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      res_b    = 128'h0123456789abcdeffedcba9876543210;
      res_c    = 128'hdeadbeefcafef00d0badc0de12345678;

      tbl[0]  = '{1'b0, 8'h31, 8'h00, 8'h00};
      tbl[1]  = '{1'b0, 8'h3F, 8'h00, 8'hA5};
      tbl[2]  = '{1'b0, 8'h05, 8'h00, 8'h00};
      tbl[3]  = '{1'b0, 8'h30, 8'h00, 8'h00};
      tbl[4]  = '{1'b0, 8'h50, 8'h00, 8'h00};
      tbl[5]  = '{1'b1, 8'h30, 8'h04, 8'h00};
      tbl[6]  = '{1'b0, 8'h30, 8'h00, 8'h04};
      tbl[7]  = '{1'b1, 8'h20, 8'h55, 8'h00};
      tbl[8]  = '{1'b0, 8'h20, 8'h00, 8'h00};
      tbl[9]  = '{1'b1, 8'h31, 8'hFF, 8'h00};
      tbl[10] = '{1'b0, 8'h31, 8'h00, 8'h00};
      tbl[11] = '{1'b1, 8'h30, 8'h00, 8'h00};
      tbl[12] = '{1'b0, 8'h30, 8'h00, 8'h00};
      tbl[13] = '{1'b1, 8'h07, 8'h3C, 8'h00};
      tbl[14] = '{1'b0, 8'h07, 8'h00, 8'h3C};
      tbl[15] = '{1'b0, 8'h17, 8'h00, 8'h00};
      tbl[16] = '{1'b1, 8'h1F, 8'hC3, 8'h00};
      tbl[17] = '{1'b0, 8'h1F, 8'h00, 8'hC3};
      tbl[18] = '{1'b1, 8'h3F, 8'h12, 8'h00};
      tbl[19] = '{1'b0, 8'h3F, 8'h00, 8'hA5};

      // Reset and register map
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check8("rst_rdata", rdata, 8'h00);
      check8("rst_core_start", {7'b0, core_start}, 8'h00);
      check8("rst_irq", {7'b0, irq}, 8'h00);
      check("rst_core_key", core_key, '0);
      for (int i = 0; i < 20; i++) begin
         if (tbl[i].wen) begin
            bus_write(tbl[i].addr, tbl[i].data);
         end else begin
            bus_read(tbl[i].addr, s);
            check8($sformatf("tbl%0d_rd_%0h", i, tbl[i].addr), s, tbl[i].exp);
         end
      end

      // FIPS-197 operation
      for (int i = 0; i < 16; i++) bus_write(8'(i), 8'(i));
      for (int i = 0; i < 16; i++) bus_write(8'(16 + i), 8'(17 * i));
      check("fips_key", core_key, 128'h000102030405060708090a0b0c0d0e0f);
      check("fips_pt", core_din, 128'h00112233445566778899aabbccddeeff);
      sc0 = start_count;
      bus_write(8'h30, 8'h05);
      check8("fips_start_hi", {7'b0, core_start}, 8'h01);
      idle_cycle();
      check8("fips_start_lo", {7'b0, core_start}, 8'h00);
      bus_read(8'h31, s);
      check8("fips_status_busy", s, 8'h01);
      repeat (3) idle_cycle();
      bus_read(8'h31, s);
      check8("fips_status_busy2", s, 8'h01);
      pulse_done(fips_res);
      check("fips_start_pulses", 128'(start_count - sc0), 128'd1);
      bus_read(8'h31, s);
      check8("fips_status_done", s, 8'h02);
      check8("fips_irq", {7'b0, irq}, 8'h01);
      for (int i = 0; i < 16; i++) begin
         bus_read(8'(8'h20 + i), s);
         check8($sformatf("fips_res%0d", i), s, fips_res[127 - 8*i -: 8]);
      end

      // Busy protection
      bus_write(8'h30, 8'h06);
      bus_read(8'h31, s);
      check8("bp_cleared", s, 8'h00);
      sc0 = start_count;
      bus_write(8'h30, 8'h05);
      idle_cycle();
      bus_write(8'h00, 8'hFF);
      bus_write(8'h30, 8'h01);
      check8("bp_key_byte0", core_key[127:120], 8'h00);
      bus_read(8'h31, s);
      check8("bp_status_busy_err", s, 8'h05);
      pulse_done(res_b);
      check("bp_start_pulses", 128'(start_count - sc0), 128'd1);
      bus_read(8'h31, s);
      check8("bp_status_after", s, 8'h06);
      check8("bp_irq_en_rewritten", {7'b0, irq}, 8'h00);

      // Timeout with a core that never answers
      bus_write(8'h30, 8'h02);
      sc0 = start_count;
      bus_write(8'h30, 8'h01);
      busy_cnt = 0;
      last = 8'hEE;
      for (int k = 0; k < 100; k++) begin
         bus_read(8'h31, s);
         if (s[0]) busy_cnt++;
         else if (busy_cnt > 0) begin
            last = s;
            break;
         end
      end
      check("to_busy_cycles", 128'(busy_cnt), 128'd64);
      check8("to_status", last, 8'h04);
      check("to_start_pulses", 128'(start_count - sc0), 128'd1);
      for (int i = 0; i < 16; i++) begin
         bus_read(8'(8'h20 + i), s);
         check8($sformatf("to_res%0d", i), s, res_b[127 - 8*i -: 8]);
      end
      bus_write(8'h30, 8'h05);
      check8("to_restart", {7'b0, core_start}, 8'h01);
      idle_cycle();
      pulse_done(res_c);
      bus_read(8'h31, s);
      check8("to_restart_status", s, 8'h06);
      check8("to_restart_irq", {7'b0, irq}, 8'h01);

      // Clear, then clear+start together
      bus_write(8'h30, 8'h02);
      bus_read(8'h31, s);
      check8("clr_status", s, 8'h00);
      check8("clr_irq", {7'b0, irq}, 8'h00);
      bus_write(8'h30, 8'h03);
      check8("cs_start", {7'b0, core_start}, 8'h01);
      idle_cycle();
      bus_read(8'h31, s);
      check8("cs_status", s, 8'h01);
      bus_write(8'h30, 8'h03);
      bus_read(8'h31, s);
      check8("cs_busy_err_survives", s, 8'h05);

      // Reset while BUSY, then a stray core_done
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      idle_cycle();
      idle_cycle();
      pulse_done(fips_res);
      bus_read(8'h31, s);
      check8("rm_status", s, 8'h00);
      check8("rm_irq", {7'b0, irq}, 8'h00);
      check("rm_core_key", core_key, '0);
      for (int i = 0; i < 16; i++) begin
         bus_read(8'(8'h20 + i), s);
         check8($sformatf("rm_res%0d", i), s, 8'h00);
      end

      // Randomized phase against the register-map model
      for (int i = 0; i < 16; i++) begin
         key_m[i] = 8'h00; pt_m[i] = 8'h00; res_m[i] = 8'h00;
      end
      done_m = 1'b0; err_m = 1'b0; irq_en_m = 1'b0;
      for (int n = 0; n < 400; n++) begin
         logic [7:0] a, d;
         logic       w;
         if ($urandom_range(0, 24) == 0) begin
            d = {5'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
            bus_write(8'h30, d);
            if (d[1]) begin done_m = 1'b0; err_m = 1'b0; end
            irq_en_m = d[2];
            idle_cycle();
            check("rnd_core_key", core_key, pack(key_m));
            check("rnd_core_din", core_din, pack(pt_m));
            tmp = {$urandom, $urandom, $urandom, $urandom};
            pulse_done(tmp);
            done_m = 1'b1;
            for (int i = 0; i < 16; i++) res_m[i] = tmp[127 - 8*i -: 8];
         end else begin
            if ($urandom_range(0, 9) < 8) a = 8'($urandom_range(0, 63));
            else a = 8'($urandom_range(0, 255));
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            if (w) begin
               if (a == 8'h30) d[0] = 1'b0;
               bus_write(a, d);
               if (a < 8'h10) key_m[a[3:0]] = d;
               else if (a < 8'h20) pt_m[a[3:0]] = d;
               else if (a == 8'h30) begin
                  if (d[1]) begin done_m = 1'b0; err_m = 1'b0; end
                  irq_en_m = d[2];
               end
            end else begin
               bus_read(a, s);
               check8($sformatf("rnd%0d_rd_%0h", n, a), s, model_read(a));
            end
         end
         check8($sformatf("rnd%0d_irq", n), {7'b0, irq}, {7'b0, done_m & irq_en_m});
      end
      check("rnd_final_key", core_key, pack(key_m));
      check("rnd_final_pt", core_din, pack(pt_m));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
